// File: rtl/if_stage_pkg.sv
// Shared fetch-pipeline definitions: word width, PC step, bubble value and
// the fetch FSM state encoding.
package if_stage_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t PC_INC   = 32'd4;
  localparam word_t NOP_WORD = '0;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/if_stage_reg.sv
// Fetch output register plus a one-entry hold buffer for a word that
// arrives while decode is frozen.
module if_stage_reg
  import if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  restore,
  input  logic  hold,
  input  logic  clear,
  input  logic  buf_load,
  input  word_t fetch_word,
  input  word_t fetch_pc,
  output word_t instr,
  output word_t pc_out,
  output logic  valid
);

  word_t buf_word;
  word_t buf_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_WORD;
      pc_out   <= NOP_WORD;
      valid    <= 1'b0;
      buf_word <= NOP_WORD;
      buf_pc   <= NOP_WORD;
    end else if (clear) begin
      instr    <= NOP_WORD;
      pc_out   <= NOP_WORD;
      valid    <= 1'b0;
      buf_word <= NOP_WORD;
      buf_pc   <= NOP_WORD;
    end else begin
      if (buf_load) begin
        buf_word <= fetch_word;
        buf_pc   <= fetch_pc;
      end
      // Priority: fresh word, then buffered word, then hold, else bubble.
      if (load) begin
        instr  <= fetch_word;
        pc_out <= fetch_pc;
        valid  <= 1'b1;
      end else if (restore) begin
        instr  <= buf_word;
        pc_out <= buf_pc;
        valid  <= 1'b1;
      end else if (!hold) begin
        instr  <= NOP_WORD;
        pc_out <= NOP_WORD;
        valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, request/response FSM with stall and redirect
// handling, feeding the output register / hold buffer.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        valid
);

  state_t state;
  word_t  pc;
  word_t  pc_next;
  word_t  discard_addr;
  word_t  target;

  logic load;
  logic restore;
  logic hold;
  logic clear;
  logic buf_load;

  assign pc_next = pc + PC_INC;
  assign target  = {branch_addr[31:2], 2'b00};

  // A redirected request keeps its original address until the memory answers.
  assign imem_req  = (state != HOLD);
  assign imem_addr = (state == DISCARD) ? discard_addr : pc;

  always_comb begin
    load     = 1'b0;
    restore  = 1'b0;
    buf_load = 1'b0;
    hold     = freeze;
    clear    = branch_taken;
    if (!branch_taken) begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (freeze) buf_load = 1'b1;
            else        load     = 1'b1;
          end
        end
        HOLD:    restore = !freeze;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= NOP_WORD;
      discard_addr <= NOP_WORD;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            pc <= target;
            if (!imem_ack) begin
              discard_addr <= pc;
              state        <= DISCARD;
            end
          end else if (imem_ack) begin
            pc <= pc_next;
            if (freeze) state <= HOLD;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc    <= target;
            state <= FETCH;
          end else if (!freeze) begin
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (branch_taken) pc <= target;
          if (imem_ack)     state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_stage_reg u_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .restore    (restore),
    .hold       (hold),
    .clear      (clear),
    .buf_load   (buf_load),
    .fetch_word (imem_rdata),
    .fetch_pc   (pc_next),
    .instr      (Instruction),
    .pc_out     (PC),
    .valid      (valid)
  );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 freeze  input  1  hazard stall from decode; hold outputs and PC.
REQ-004 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-005 branch_addr  input  32  redirect target byte address.
REQ-006 imem_req  output  1  instruction-memory request; held until imem_ack.
REQ-007 imem_addr  output  32  fetch address; equals pc while imem_req=1.
REQ-008 imem_ack  input  1  one-cycle response strobe; may assert in the first request cycle.
REQ-009 imem_rdata  input  32  instruction word; valid only with imem_ack.
REQ-010 Instruction  output  32  fetched word to decode; 0 when not valid.
REQ-011 PC  output  32  fetch address + 4 of the presented Instruction.
REQ-012 valid  output  1  Instruction/PC carry a real instruction.

Function
REQ-013 pc register SHALL be 32 bits, word aligned, incremented by 4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-014 FSM states SHALL be FETCH (imem_req=1), HOLD (imem_req=0, word buffered), DISCARD (imem_req=1, response to be dropped).
REQ-015 FETCH, imem_ack=1, freeze=0, branch_taken=0: Instruction<=imem_rdata, PC<=pc+4, valid<=1, pc<=pc+4, stay FETCH.
REQ-016 FETCH, imem_ack=1, freeze=1, branch_taken=0: word and pc+4 SHALL go to hold buffer, outputs unchanged, pc<=pc+4, go HOLD.
REQ-017 HOLD, freeze=0: hold buffer SHALL load the output register with valid=1, go FETCH; HOLD with freeze=1 stays.
REQ-018 freeze=0 with no instruction delivered that cycle: output register SHALL load bubble (valid=0, Instruction=0, PC=0).
REQ-019 freeze=1 and branch_taken=0: output register SHALL hold its value.
REQ-020 branch_taken SHALL override freeze: pc<=branch_addr, output register and hold buffer cleared (valid=0).
REQ-021 branch_taken in FETCH with imem_ack=1 same cycle: returned word dropped, next state FETCH at branch_addr.
REQ-022 branch_taken in FETCH without imem_ack: next state DISCARD; imem_addr SHALL stay at old address until ack.
REQ-023 DISCARD, imem_ack=1: word dropped, go FETCH at redirected pc; a further branch_taken in DISCARD updates pc, stays DISCARD.
REQ-024 branch_taken in HOLD: buffer discarded, go FETCH at branch_addr.
REQ-025 imem_addr SHALL not change while imem_req=1 and imem_ack=0.
REQ-026 Minimum latency: ack in request cycle yields valid=1 at next rising edge; back-to-back single-cycle acks yield one instruction per cycle.

Reset
REQ-027 rst=1 SHALL asynchronously set pc=0, state=FETCH, valid=0, Instruction=0, PC=0, hold buffer cleared.
REQ-028 First cycle after rst release SHALL present imem_req=1, imem_addr=0.
REQ-029 Reset mid-request SHALL abandon the outstanding fetch; the memory model SHALL also be reset.

Structure
REQ-030 Shared pipeline package SHALL hold word width (32), PC increment (4), NOP/bubble value (0), FSM state encoding.
REQ-031 Output register + hold buffer SHALL be one sub-module, if_stage_reg (load, hold, clear controls).
REQ-032 Remaining logic (pc, FSM, adder) SHALL live in if_stage; no other instances.

Verification
REQ-033 Zero-wait memory, no stalls: after reset, valid rises at cycle 1; PC sequence 4, 8, 12.
REQ-034 Memory ack 3 cycles after req: imem_addr stable 3 cycles; valid=1 one cycle after ack, 0 otherwise.
REQ-035 freeze=1 for 2 cycles while ack arrives at pc=8: outputs hold PC=8; after release PC=12, then 16, none lost or duplicated.
REQ-036 branch_taken to 0x100 while fetch of 0x20 pending: ack for 0x20 dropped; next valid word from 0x100, PC=0x104.
REQ-037 branch_taken and freeze together in HOLD: valid=0 next cycle, fetch restarts at branch_addr.
REQ-038 pc=0xFFFFFFFC, zero-wait memory: PC=0x00000000, next imem_addr=0x00000000; rst mid-fetch returns imem_addr=0.
